// File: rtl/latch_chain_pkg.sv
// Shared types and constants for the latch-chain stimulus/check driver.
package latch_chain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        DRIVE,
        FLUSH,
        DONE
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback taps on bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DFLT = 16'hACE1;

    // One Fibonacci step, shifting left with the feedback entering bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and step.
module lfsr16
    import latch_chain_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [15:0] seed_i,
    output logic [15:0] q_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Load has priority over step; otherwise hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (step_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // State register; reset to the default seed so the register is never all-zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED_DFLT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/latch_chain_driver.sv
// Drives pseudo-random enable/data into the latch at the head of a latch+flop
// chain and checks the value returning from its tail against an internal model.
module latch_chain_driver
    import latch_chain_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter bit INV   = 1'b0,
    parameter int LEN_W = 16,
    parameter int ERR_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [15:0]      i_seed,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_en,
    output logic             o_a,
    input  logic             i_chain_q,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [LEN_W-1:0] o_first_err
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               en_q, en_d;
    logic               a_q, a_d;
    logic               lfsr_load, lfsr_step, run_clr;
    logic [15:0]        lfsr_q;
    logic [15:0]        seed_eff;

    // Model latch and the delay line standing in for the chain's flop stages.
    logic               lat_q, lat_d;
    logic [DEPTH-1:0]   exp_pipe_q;
    logic [DEPTH-1:0]   vld_pipe_q;
    logic               chk, mis;

    logic [LEN_W-1:0]   chk_idx_q, chk_idx_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [LEN_W-1:0]   first_q, first_d;
    logic               pass_q, pass_d;

    // Upper LFSR bits only feed the LFSR's own next state.
    logic               unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_q[15:2];

    assign seed_eff = (i_seed == 16'h0) ? LFSR_SEED_DFLT : i_seed;

    lfsr16 u_lfsr (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .load_i (lfsr_load),
        .step_i (lfsr_step),
        .seed_i (seed_eff),
        .q_o    (lfsr_q)
    );

    // Next-state and next-output decode. The LFSR is loaded as the run is
    // accepted, so SEED already sees the seed and registers the forced-enable
    // first drive; each DRIVE cycle registers the following sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        en_d      = 1'b0;
        a_d       = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        run_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    run_clr   = 1'b1;
                    lfsr_load = 1'b1;
                    if (i_len != '0) begin
                        state_d = SEED;
                        cnt_d   = i_len;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SEED: begin
                en_d      = 1'b1;
                a_d       = lfsr_q[1];
                lfsr_step = 1'b1;
                state_d   = DRIVE;
            end
            DRIVE: begin
                lfsr_step = 1'b1;
                if (cnt_q == LEN_W'(1)) begin
                    state_d = FLUSH;
                    cnt_d   = LEN_W'(DEPTH);
                end else begin
                    en_d  = lfsr_q[0];
                    a_d   = lfsr_q[1];
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            FLUSH: begin
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Checker: compare tail against the delayed model value, count mismatches.
    always_comb begin
        lat_d     = en_q ? a_q : lat_q;
        chk       = vld_pipe_q[DEPTH-1];
        mis       = chk & (i_chain_q != (exp_pipe_q[DEPTH-1] ^ INV));
        chk_idx_d = chk_idx_q;
        err_d     = err_q;
        first_d   = first_q;
        pass_d    = pass_q;
        if (run_clr) begin
            chk_idx_d = '0;
            err_d     = '0;
            first_d   = '1;
            pass_d    = 1'b0;
        end else begin
            if (chk) begin
                chk_idx_d = chk_idx_q + LEN_W'(1);
            end
            if (mis) begin
                if (err_q != '1) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (err_q == '0) begin
                    first_d = chk_idx_q;
                end
            end
        end
        // Verdict includes a mismatch found on the very edge into DONE.
        if (state_d == DONE) begin
            pass_d = (err_d == '0);
        end
    end

    // FSM, drive outputs and checker state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            a_q       <= 1'b0;
            chk_idx_q <= '0;
            err_q     <= '0;
            first_q   <= '1;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            a_q       <= a_d;
            chk_idx_q <= chk_idx_d;
            err_q     <= err_d;
            first_q   <= first_d;
            pass_q    <= pass_d;
        end
    end

    // Model latch plus DEPTH-stage value/valid pipeline; valid enters only in DRIVE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lat_q      <= 1'b0;
            exp_pipe_q <= '0;
            vld_pipe_q <= '0;
        end else begin
            lat_q         <= lat_d;
            exp_pipe_q[0] <= lat_d;
            vld_pipe_q[0] <= (state_q == DRIVE);
            for (int i = 1; i < DEPTH; i++) begin
                exp_pipe_q[i] <= exp_pipe_q[i-1];
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
        end
    end

    assign o_en        = en_q;
    assign o_a         = a_q;
    assign o_busy      = (state_q == SEED) || (state_q == DRIVE) || (state_q == FLUSH);
    assign o_done      = (state_q == DONE);
    assign o_pass      = pass_q;
    assign o_err_cnt   = err_q;
    assign o_first_err = first_q;

endmodule

// File: tb/tb_latch_chain_driver.sv
// Randomized loopback bench: a behavioural latch+flop chain closes the loop,
// and an array-level reference computes the expected verdict of each run.
module tb_latch_chain_driver;

    localparam int DEPTH = 4;
    localparam int LEN_W = 16;
    localparam int ERR_W = 16;
    localparam bit INV   = 1'b0;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [15:0]      seed;
    logic [LEN_W-1:0] len;
    logic             en, a, chain_q, busy, done, pass;
    logic [ERR_W-1:0] errc;
    logic [LEN_W-1:0] first;

    int n_cmp = 0;
    int n_bad = 0;

    // Chain fault injection: 0 none, 1 invert one check index, 2 stuck-0, 3 stuck-1.
    int   flt_mode = 0;
    logic flip = 1'b0;
    logic lat_hold = 1'b0;
    logic lat;
    logic [DEPTH-1:0] sr = '0;

    always #5 clk = ~clk;

    latch_chain_driver #(.DEPTH(DEPTH), .INV(INV), .LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_seed      (seed),
        .i_len       (len),
        .o_en        (en),
        .o_a         (a),
        .i_chain_q   (chain_q),
        .o_busy      (busy),
        .o_done      (done),
        .o_pass      (pass),
        .o_err_cnt   (errc),
        .o_first_err (first)
    );

    // Transparent latch followed by DEPTH flops; flip corrupts one sample in flight.
    assign lat = en ? a : lat_hold;
    always @(posedge clk) begin
        lat_hold <= lat;
        sr       <= {sr[DEPTH-2:0], lat ^ flip};
    end
    assign chain_q = (flt_mode == 2) ? 1'b0 :
                     (flt_mode == 3) ? 1'b1 : (sr[DEPTH-1] ^ INV);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk the drive sequence, track the latch value per check index,
    // and decide which returning values disagree.
    task automatic ref_run(input logic [15:0] sd, input int n, input int mode, input int fi,
                           output int e, output int f);
        logic [15:0] s;
        logic l, en_k, got;
        s = (sd == 16'h0) ? 16'hACE1 : sd;
        l = 1'b0;
        e = 0;
        f = -1;
        for (int k = 0; k < n; k++) begin
            en_k = (k == 0) ? 1'b1 : s[0];
            if (en_k) l = s[1];
            case (mode)
                2:       got = 1'b0;
                3:       got = 1'b1;
                default: got = l ^ ((mode == 1) && (k == fi));
            endcase
            if (got != l) begin
                e++;
                if (f < 0) f = k;
            end
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
        if (e > (1 << ERR_W) - 1) e = (1 << ERR_W) - 1;
    endtask

    task automatic run(input logic [15:0] sd, input int n, input int mode, input int fi,
                       input bit extra, input string tag);
        int e, f, c, busy_n, done_c, span;
        ref_run(sd, n, mode, fi, e, f);
        span = (n == 0) ? 0 : n + DEPTH + 1;
        @(negedge clk);
        seed = sd; len = LEN_W'(n); start = 1'b1; flt_mode = mode;
        @(negedge clk);
        start = 1'b0;
        c = 0; busy_n = 0; done_c = -1;
        while (c < n + DEPTH + 20) begin
            if (done) begin
                done_c = c;
                break;
            end
            if (busy) busy_n++;
            flip  = (mode == 1) && (c == fi + 1);
            start = extra && (c == 3);
            @(negedge clk);
            c++;
        end
        flip = 1'b0;
        check({tag, "_done_cyc"}, done_c, span);
        check({tag, "_busy_cyc"}, busy_n, span);
        check({tag, "_pass"}, pass, (e == 0));
        check({tag, "_err_cnt"}, errc, e);
        check({tag, "_first"}, first, (f < 0) ? 32'hFFFF : f);
        start = extra;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_pass_held"}, pass, (e == 0));
        flt_mode = 0;
    endtask

    task automatic rst_mid();
        int done_n;
        @(negedge clk);
        seed = 16'h1234; len = 16'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_mid_busy_before", busy, 1'b1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_mid_en", en, 1'b0);
        check("rst_mid_a", a, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_pass", pass, 1'b0);
        check("rst_mid_err", errc, 0);
        check("rst_mid_first", first, 32'hFFFF);
        done_n = 0;
        repeat (70) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        check("rst_mid_quiet", done_n, 0);
    endtask

    initial begin
        int n, m, fi;
        rst = 1'b1; start = 1'b1; seed = 16'h0; len = 16'd5;
        repeat (3) @(negedge clk);
        check("rst_en", en, 1'b0);
        check("rst_a", a, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", errc, 0);
        check("rst_first", first, 32'hFFFF);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        run(16'h0001, 100, 0, 0, 1'b0, "clean100");
        run(16'h0001, 100, 1, 10, 1'b0, "flip10");
        run(16'h0001, 20, 2, 0, 1'b0, "stuck0");
        run(16'h5A5A, 0, 0, 0, 1'b0, "len0");
        rst_mid();
        run(16'h0001, 30, 0, 0, 1'b0, "after_rst");
        run(16'h0000, 40, 3, 0, 1'b1, "seed0_extra");
        run(16'hACE1, 40, 3, 0, 1'b0, "seedace1");
        run(16'h0000, 40, 1, 39, 1'b0, "flip_last");
        run(16'hBEEF, 1, 1, 0, 1'b0, "len1_flip");

        for (int r = 0; r < 25; r++) begin
            n  = $urandom_range(1, 80);
            m  = $urandom_range(0, 3);
            fi = $urandom_range(0, n - 1);
            run(16'($urandom), n, m, fi, 1'($urandom), $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
